// File: rtl/imem_arbiter.sv
// Two-port arbiter (fetch F > debug D) in front of the single-port synchronous instruction ROM.
// Optional D anti-starvation guard enabled by defining IMEM_ARB_STARVE_GUARD_EN.
module imem_arbiter #(
    parameter int unsigned AW           = 14,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_dout
);

    typedef enum logic [1:0] {OwnNone, OwnF, OwnD} owner_e;

    owner_e        owner_q, owner_d;
    logic [AW-1:0] last_addr_q;
    logic [DW-1:0] f_hold_q, d_hold_q;
    logic          force_d;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    // Extra headroom bit keeps the width non-zero for STARVE_LIMIT == 0.
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 2);

    logic [CW-1:0] starve_q, starve_d;

    assign force_d = d_req && (starve_q == CW'(STARVE_LIMIT));

    always_comb begin
        starve_d = '0;
        if (d_req && !d_gnt) begin
            starve_d = (starve_q == CW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign force_d = 1'b0;
`endif

    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            f_gnt = f_req && !force_d;
            d_gnt = d_req && (!f_req || force_d);
        end
    end

    // Without a grant the ROM address is parked on the last one issued.
    always_comb begin
        rom_addr = last_addr_q;
        owner_d  = OwnNone;
        if (f_gnt) begin
            rom_addr = f_addr;
            owner_d  = OwnF;
        end else if (d_gnt) begin
            rom_addr = d_addr;
            owner_d  = OwnD;
        end
    end

    always_comb begin
        f_rvalid = (owner_q == OwnF);
        d_rvalid = (owner_q == OwnD);
        f_rdata  = f_rvalid ? rom_dout : f_hold_q;
        d_rdata  = d_rvalid ? rom_dout : d_hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OwnNone;
            last_addr_q <= '0;
            f_hold_q    <= '0;
            d_hold_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            last_addr_q <= rom_addr;
            if (f_rvalid) f_hold_q <= rom_dout;
            if (d_rvalid) d_hold_q <= rom_dout;
        end
    end

endmodule
